// File: rtl/tdm_demux_1_4.sv
// 4-slot time-division demultiplexer: rebuilds four parallel channels from a serialized stream.
// Optional TDM_STRICT_SYNC_EN: a missing frame_sync at slot 0 while locked drops back to HUNT.
module tdm_demux_1_4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [4*WIDTH-1:0] out,
  output logic [1:0]         s,
  output logic               frame_valid,
  output logic               locked,
  output logic               sync_err
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] stage0;
  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;

  // Early sync outranks completion: a slot-3 sample carrying frame_sync restarts the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      s           <= 2'd0;
      stage0      <= '0;
      stage1      <= '0;
      stage2      <= '0;
      out         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        if (state == HUNT) begin
          if (frame_sync) begin
            stage0 <= din;
            s      <= 2'd1;
            state  <= LOCKED;
          end
        end else if (frame_sync) begin
          if (s != 2'd0) begin
            sync_err <= 1'b1;
          end
          stage0 <= din;
          s      <= 2'd1;
        end else begin
          case (s)
            2'd0: begin
`ifdef TDM_STRICT_SYNC_EN
              sync_err <= 1'b1;
              state    <= HUNT;
              s        <= 2'd0;
`else
              stage0 <= din;
              s      <= 2'd1;
`endif
            end
            2'd1: begin
              stage1 <= din;
              s      <= 2'd2;
            end
            2'd2: begin
              stage2 <= din;
              s      <= 2'd3;
            end
            default: begin
              out         <= {din, stage2, stage1, stage0};
              s           <= 2'd0;
              frame_valid <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Self-checking bench for tdm_demux_1_4: directed test-plan frames followed by a randomized stream,
// compared cycle by cycle against a slot/frame reference model (honours TDM_STRICT_SYNC_EN).
module tb_tdm_demux_1_4;

  localparam int W = 1;

  logic           clk;
  logic           rst;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [4*W-1:0] out_w;
  logic [1:0]     s_w;
  logic           frame_valid_w;
  logic           locked_w;
  logic           sync_err_w;

  int checks;
  int failures;

  // Reference model: channel samples collected per slot, frame published as a whole.
  bit m_locked;
  int m_slot;
  int m_chan [4];
  int m_out;
  bit m_fv;
  bit m_err;

  tdm_demux_1_4 #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .frame_sync(frame_sync),
    .out(out_w),
    .s(s_w),
    .frame_valid(frame_valid_w),
    .locked(locked_w),
    .sync_err(sync_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    m_locked = 0;
    m_slot   = 0;
    m_out    = 0;
    m_fv     = 0;
    m_err    = 0;
    for (int k = 0; k < 4; k++) m_chan[k] = 0;
  endfunction

  function automatic void modelStep(input bit v, input bit fs, input int d);
    m_fv  = 0;
    m_err = 0;
    if (!v) return;
    if (!m_locked) begin
      if (fs) begin
        m_chan[0] = d;
        m_slot    = 1;
        m_locked  = 1;
      end
    end else if (fs) begin
      m_err     = (m_slot != 0);
      m_chan[0] = d;
      m_slot    = 1;
    end else if (m_slot == 0) begin
`ifdef TDM_STRICT_SYNC_EN
      m_err    = 1;
      m_locked = 0;
`else
      m_chan[0] = d;
      m_slot    = 1;
`endif
    end else begin
      m_chan[m_slot] = d;
      if (m_slot == 3) begin
        m_out = 0;
        for (int k = 0; k < 4; k++) m_out = m_out + m_chan[k] * (1 << (k * W));
        m_fv   = 1;
        m_slot = 0;
      end else begin
        m_slot = m_slot + 1;
      end
    end
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    checkValue("out", 32'(out_w), 32'(m_out));
    checkValue("s", 32'(s_w), 32'(m_slot));
    checkValue("frame_valid", 32'(frame_valid_w), 32'(m_fv));
    checkValue("locked", 32'(locked_w), 32'(m_locked));
    checkValue("sync_err", 32'(sync_err_w), 32'(m_err));
  endtask

  // Drive one cycle, advance the model past the edge, then check just after the edge.
  task automatic applyStimulus(input bit v, input bit fs, input int d);
    din_valid  = v;
    frame_sync = fs;
    din        = W'(d);
    @(posedge clk);
    modelStep(v, fs, d);
    #1;
    checkOutput();
  endtask

  task automatic sendFrame(input logic [3:0] f, input int gap);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, k == 0, int'(f[k]));
      if (k < 3)
        for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    logic [3:0] frames [4];
    frames[0] = 4'b0010;
    frames[1] = 4'b0100;
    frames[2] = 4'b1000;
    frames[3] = 4'b1100;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    // First frame after reset, then a cycle later the pulse must be gone.
    sendFrame(4'b0001, 0);
    checkValue("first_frame", 32'(out_w), 32'h1);
    checkValue("first_fv", 32'(frame_valid_w), 32'h1);
    applyStimulus(1'b0, 1'b0, 0);
    checkValue("first_fv_gone", 32'(frame_valid_w), 32'h0);

    for (int i = 0; i < 4; i++) begin
      sendFrame(frames[i], 0);
      checkValue("b2b_frame", 32'(out_w), 32'(frames[i]));
    end

    // Early sync at slot 2, then the restarted frame publishes 1010.
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 0);
    checkValue("early_sync_err", 32'(sync_err_w), 32'h1);
    checkValue("early_sync_out", 32'(out_w), 32'(frames[3]));
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1);
    checkValue("restart_frame", 32'(out_w), 32'hA);

    sendFrame(4'b0110, 3);
    checkValue("gapped_frame", 32'(out_w), 32'h6);

    // Asynchronous reset in the middle of a frame.
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    checkValue("async_rst_out", 32'(out_w), 32'h0);
    #1 rst = 1'b0;
    sendFrame(4'b1111, 0);
    checkValue("post_rst_frame", 32'(out_w), 32'hF);

    // Missing sync at slot 0 while locked.
    sendFrame(4'b0001, 0);
    applyStimulus(1'b1, 1'b0, 1);
`ifdef TDM_STRICT_SYNC_EN
    checkValue("missing_sync_locked", 32'(locked_w), 32'h0);
    checkValue("missing_sync_err", 32'(sync_err_w), 32'h1);
`else
    checkValue("missing_sync_locked", 32'(locked_w), 32'h1);
    checkValue("missing_sync_err", 32'(sync_err_w), 32'h0);
`endif

    // Randomized stream: mostly well-aligned syncs, occasional gaps and stray syncs.
    for (int n = 0; n < 600; n++) begin
      bit v;
      bit fs;
      v = ($urandom_range(0, 3) != 0);
      if (m_slot == 0)
        fs = ($urandom_range(0, 9) < 8);
      else
        fs = ($urandom_range(0, 19) == 0);
      applyStimulus(v, fs, int'($urandom_range(0, (1 << W) - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
